// File: rtl/instr_fetch_mem_if.sv
// Program-load and instruction-fetch bus for instr_fetch_mem.
// The master drives programming and fetch requests; the slave is the memory.
interface instr_fetch_mem_if #(
  parameter int ADDR_W = 64
);
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [31:0]       prog_data;
  logic              boot_done;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [31:0]       fetch_instr;
  logic              fetch_fault;
  logic              prog_err;
  logic [31:0]       fetch_count;

  modport master (
    output prog_we, prog_addr, prog_data, boot_done, fetch_req, fetch_addr,
    input  fetch_ready, fetch_valid, fetch_instr, fetch_fault, prog_err, fetch_count
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, boot_done, fetch_req, fetch_addr,
    output fetch_ready, fetch_valid, fetch_instr, fetch_fault, prog_err, fetch_count
  );
endinterface

// File: rtl/instr_fetch_mem.sv
// Byte-addressed instruction store: loaded word-by-word in LOAD, then serves
// registered one-cycle-latency fetches in RUN. Memory contents survive reset.
module instr_fetch_mem #(
  parameter int          DEPTH_BYTES = 256,
  parameter int          ADDR_W      = 64,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  instr_fetch_mem_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W+1)'(DEPTH_BYTES);
  localparam logic [ADDR_W:0] LAST_OFS = (ADDR_W+1)'(3);

  typedef enum logic {ST_LOAD, ST_RUN} state_e;

  state_e state_q, state_d;

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic        fault_q, fault_d;
  logic        prog_err_q, prog_err_d;
  logic [31:0] count_q, count_d;

  logic fetch_ready, accept, wr_en, prog_err_set;
  logic fetch_ok, prog_ok;

  logic [7:0] mem [DEPTH_BYTES];

  // Extra top bit keeps addr+3 from wrapping near the top of the address space.
  function automatic logic word_ok(input logic [ADDR_W-1:0] a);
    return (a[1:0] == 2'b00) && (({1'b0, a} + LAST_OFS) < DEPTH_X);
  endfunction

  assign fetch_ok = word_ok(bus.fetch_addr);
  assign prog_ok  = word_ok(bus.prog_addr);

  wire [IDX_W-3:0] wr_wi = bus.prog_addr[IDX_W-1:2];
  wire [IDX_W-3:0] rd_wi = bus.fetch_addr[IDX_W-1:2];
  wire [31:0] rd_word = {mem[{rd_wi, 2'd3}], mem[{rd_wi, 2'd2}],
                         mem[{rd_wi, 2'd1}], mem[{rd_wi, 2'd0}]};

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_LOAD;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (state_q == ST_LOAD && bus.boot_done) state_d = ST_RUN;
  end

  // FSM: outputs
  always_comb begin
    fetch_ready  = (state_q == ST_RUN);
    accept       = bus.fetch_req & fetch_ready;
    wr_en        = bus.prog_we & (state_q == ST_LOAD) & prog_ok;
    prog_err_set = bus.prog_we & ~wr_en;
  end

  always_comb begin
    valid_d    = accept;
    instr_d    = instr_q;
    fault_d    = fault_q;
    prog_err_d = prog_err_q | prog_err_set;
    count_d    = count_q;
    if (accept) begin
      instr_d = fetch_ok ? rd_word : NOP_WORD;
      fault_d = ~fetch_ok;
      if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      instr_q    <= 32'd0;
      fault_q    <= 1'b0;
      prog_err_q <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      fault_q    <= fault_d;
      prog_err_q <= prog_err_d;
      count_q    <= count_d;
    end
  end

  // Storage is not reset; a write coinciding with reset is suppressed.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[{wr_wi, 2'd0}] <= bus.prog_data[7:0];
      mem[{wr_wi, 2'd1}] <= bus.prog_data[15:8];
      mem[{wr_wi, 2'd2}] <= bus.prog_data[23:16];
      mem[{wr_wi, 2'd3}] <= bus.prog_data[31:24];
    end
  end

  assign bus.fetch_ready = fetch_ready;
  assign bus.fetch_valid = valid_q;
  assign bus.fetch_instr = instr_q;
  assign bus.fetch_fault = fault_q;
  assign bus.prog_err    = prog_err_q;
  assign bus.fetch_count = count_q;
endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem: expected fetch responses are queued
// with their due cycle when driven and checked by a negedge monitor.
module tb_instr_fetch_mem;
  localparam int          DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    logic        fault;
    int          due;
  } exp_t;

  logic clk, reset;
  instr_fetch_mem_if #(.ADDR_W(64)) bus ();

  instr_fetch_mem #(.DEPTH_BYTES(DEPTH), .ADDR_W(64), .NOP_WORD(NOP)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic rst_edge = 1'b0;
  bit mon_en = 1'b0;

  exp_t sb[$];
  logic [7:0]  mem_m [DEPTH];
  bit          run_m  = 1'b0;
  bit          perr_m = 1'b0;
  logic [31:0] cnt_m  = 32'd0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= reset;
  end

  // Monitor: response timing/content, and hold of fetch_instr/fetch_fault when idle.
  exp_t        mon_e;
  logic [31:0] last_instr = 32'd0;
  logic        last_fault = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_edge) begin
        last_instr = 32'd0;
        last_fault = 1'b0;
      end
      if (bus.fetch_valid) begin
        checks++;
        if (sb.size() == 0 || sb[0].due != cyc) begin
          errors++;
          $display("FAIL unexpected_valid: fetch_valid=1 at cycle %0d, required 0", cyc);
        end else begin
          mon_e = sb.pop_front();
          if ({bus.fetch_instr, bus.fetch_fault} !== {mon_e.instr, mon_e.fault}) begin
            errors++;
            $display("FAIL response: instr=%h fault=%b at cycle %0d, required instr=%h fault=%b",
                     bus.fetch_instr, bus.fetch_fault, cyc, mon_e.instr, mon_e.fault);
          end
          last_instr = mon_e.instr;
          last_fault = mon_e.fault;
        end
      end else begin
        if (sb.size() != 0 && sb[0].due <= cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_valid: fetch_valid=0 at cycle %0d, required 1", cyc);
          void'(sb.pop_front());
        end
        checks++;
        if ({bus.fetch_instr, bus.fetch_fault} !== {last_instr, last_fault}) begin
          errors++;
          $display("FAIL hold: instr=%h fault=%b while idle, required instr=%h fault=%b",
                   bus.fetch_instr, bus.fetch_fault, last_instr, last_fault);
        end
      end
    end
  end

  function automatic exp_t mk_exp(input logic [63:0] a);
    exp_t e;
    int   i;
    if (a[1:0] != 2'b00 || a > 64'(DEPTH - 4)) begin
      e.instr = NOP;
      e.fault = 1'b1;
    end else begin
      i = int'(a);
      e.instr = {mem_m[i+3], mem_m[i+2], mem_m[i+1], mem_m[i]};
      e.fault = 1'b0;
    end
    e.due = cyc + 1;
    return e;
  endfunction

  task automatic check_status(input string tag);
    checks += 3;
    if (bus.fetch_ready !== run_m) begin
      errors++;
      $display("FAIL %s_ready: got %b, required %b", tag, bus.fetch_ready, run_m);
    end
    if (bus.fetch_count !== cnt_m) begin
      errors++;
      $display("FAIL %s_count: got %0d, required %0d", tag, bus.fetch_count, cnt_m);
    end
    if (bus.prog_err !== perr_m) begin
      errors++;
      $display("FAIL %s_prog_err: got %b, required %b", tag, bus.prog_err, perr_m);
    end
  endtask

  // All drive tasks start and end just after a negedge.
  task automatic fetch(input logic [63:0] a);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = a;
    if (run_m) begin
      sb.push_back(mk_exp(a));
      if (cnt_m != 32'hFFFF_FFFF) cnt_m++;
    end
    @(negedge clk);
    bus.fetch_req = 1'b0;
  endtask

  task automatic prog(input logic [63:0] a, input logic [31:0] d);
    bus.prog_we   = 1'b1;
    bus.prog_addr = a;
    bus.prog_data = d;
    if (!run_m && a[1:0] == 2'b00 && a <= 64'(DEPTH - 4)) begin
      for (int b = 0; b < 4; b++) mem_m[int'(a) + b] = d[8*b +: 8];
    end else begin
      perr_m = 1'b1;
    end
    @(negedge clk);
    bus.prog_we = 1'b0;
  endtask

  task automatic boot();
    bus.boot_done = 1'b1;
    @(negedge clk);
    bus.boot_done = 1'b0;
    run_m = 1'b1;
  endtask

  task automatic do_reset(input bit with_fetch, input bit with_prog);
    reset = 1'b1;
    if (with_fetch) begin bus.fetch_req = 1'b1; bus.fetch_addr = 64'd4; end
    if (with_prog)  begin bus.prog_we = 1'b1; bus.prog_addr = 64'd8; bus.prog_data = 32'hDEAD_BEEF; end
    @(negedge clk);
    reset = 1'b0;
    bus.fetch_req = 1'b0;
    bus.prog_we   = 1'b0;
    run_m  = 1'b0;
    perr_m = 1'b0;
    cnt_m  = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks += 3;
    if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", bus.fetch_valid); end
    if (bus.fetch_instr !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h, required 0", bus.fetch_instr); end
    if (bus.fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b, required 0", bus.fetch_fault); end
    check_status("reset");
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_load_ignore();
    for (int i = 0; i < 5; i++) begin
      fetch(64'd4);
      checks++;
      if (bus.fetch_ready !== 1'b0) begin errors++; $display("FAIL load_ready: got %b, required 0", bus.fetch_ready); end
    end
    check_status("load_ignore");
  endtask

  task automatic test_program();
    prog(64'd0,   32'h0000_0093);
    prog(64'd4,   32'h0050_3223);
    prog(64'd8,   32'h1234_5678);
    prog(64'd252, 32'hCAFE_F00D);
    check_status("prog_ok");
    prog(64'd6, 32'hBAD0_0006);
    check_status("prog_misaligned");
    do_reset(1'b0, 1'b0);
    prog(64'd256, 32'hBAD0_0100);
    check_status("prog_range");
    do_reset(1'b0, 1'b1);
    check_status("reset_with_prog");
  endtask

  task automatic test_fetch_basic();
    boot();
    fetch(64'd4);
    @(negedge clk);
    check_status("fetch4");
  endtask

  task automatic test_faults();
    fetch(64'd6);
    check_status("fault_misaligned");
    fetch(64'(DEPTH - 2));
    check_status("fault_depth_m2");
    fetch(64'(DEPTH));
    fetch(64'hFFFF_FFFF_FFFF_FFFC);
    fetch(64'(DEPTH - 4));
    @(negedge clk);
    check_status("fault_range");
  endtask

  task automatic test_run_write();
    prog(64'd4, 32'hFFFF_FFFF);
    check_status("run_write");
    boot();
    check_status("boot_in_run");
    fetch(64'd4);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [63:0] addrs [6];
    addrs[0] = 64'd0;  addrs[1] = 64'd4;   addrs[2] = 64'd8;
    addrs[3] = 64'd252; addrs[4] = 64'd6;  addrs[5] = 64'd256;
    fetch(64'd0);
    fetch(64'd4);
    fetch(64'd8);
    for (int i = 0; i < 30; i++) begin
      fetch(addrs[$urandom_range(0, 5)]);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    @(negedge clk);
    check_status("b2b");
  endtask

  task automatic test_reset_inflight();
    fetch(64'd4);
    do_reset(1'b0, 1'b0);
    checks++;
    if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL inflight_valid: got %b, required 0", bus.fetch_valid); end
    check_status("reset_inflight");
    boot();
    do_reset(1'b1, 1'b0);
    check_status("reset_with_fetch");
    boot();
    fetch(64'd4);
    fetch(64'd8);
    @(negedge clk);
    check_status("after_reboot");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset          = 1'b1;
    bus.prog_we    = 1'b0;
    bus.prog_addr  = '0;
    bus.prog_data  = '0;
    bus.boot_done  = 1'b0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    @(negedge clk);
    test_reset();
    test_load_ignore();
    test_program();
    test_fetch_basic();
    test_faults();
    test_run_write();
    test_back_to_back();
    test_reset_inflight();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 Parameter DEPTH_BYTES, 256, instruction storage size in bytes; SHALL be a power of two, minimum 8.
REQ-002 Parameter ADDR_W, 64, fetch and program address width.
REQ-003 Parameter NOP_WORD, 32'h00000013, word returned on a faulted fetch (addi x0,x0,0).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 prog_we  input  1  program-port word write strobe.
REQ-008 prog_addr  input  ADDR_W  program byte address, word aligned.
REQ-009 prog_data  input  32  program word, stored little-endian.
REQ-010 boot_done  input  1  one-cycle pulse ending the load phase.
REQ-011 fetch_req  input  1  fetch request.
REQ-012 fetch_addr  input  ADDR_W  fetch byte address (PC).
REQ-013 fetch_ready  output  1  fetch accepted this cycle when high.
REQ-014 fetch_valid  output  1  response qualifier.
REQ-015 fetch_instr  output  32  fetched instruction.
REQ-016 fetch_fault  output  1  misaligned or out-of-range fetch.
REQ-017 prog_err  output  1  sticky: illegal program write seen.
REQ-018 fetch_count  output  32  count of accepted fetches, saturating.

Function
REQ-019 State machine SHALL have two states: LOAD (entered on reset) and RUN.
REQ-020 Transitions: LOAD->RUN on boot_done; RUN stays RUN; boot_done in RUN is ignored.
REQ-021 In LOAD, prog_we with prog_addr[1:0]==0 and prog_addr+3 < DEPTH_BYTES SHALL write bytes [7:0],[15:8],[23:16],[31:24] to byte addresses prog_addr..prog_addr+3.
REQ-022 A misaligned or out-of-range program write in LOAD SHALL be dropped and set prog_err.
REQ-023 prog_we in RUN SHALL be dropped and set prog_err; memory contents are unchanged.
REQ-024 fetch_ready SHALL be 1 exactly when state is RUN; fetch_req in LOAD is ignored (no response, no count).
REQ-025 Accepted fetch (fetch_req & fetch_ready) at cycle N SHALL produce fetch_valid=1 at cycle N+1 with the response, one-cycle latency, fully registered.
REQ-026 Response word = {mem[a+3],mem[a+2],mem[a+1],mem[a]}, a=fetch_addr, fetch_fault=0.
REQ-027 If fetch_addr[1:0]!=0 or fetch_addr+3 >= DEPTH_BYTES (full ADDR_W compare, no wrap-around), response SHALL be fetch_instr=NOP_WORD, fetch_fault=1.
REQ-028 Back-to-back fetches every cycle SHALL be supported; fetch_valid SHALL be 0 in any cycle following a non-accepted cycle.
REQ-029 fetch_instr and fetch_fault SHALL hold their last value while fetch_valid=0.
REQ-030 fetch_count SHALL increment by 1 per accepted fetch, faulted fetches included, and saturate at 32'hFFFFFFFF.
REQ-031 Memory read and write SHALL never occur in the same cycle because the states are exclusive; no bypass is required.

Reset
REQ-032 On reset: state=LOAD, fetch_valid=0, fetch_instr=0, fetch_fault=0, prog_err=0, fetch_count=0, fetch_ready=0 in the following cycle.
REQ-033 Reset SHALL NOT clear memory contents; power-up contents are undefined until written.
REQ-034 Reset asserted in the same cycle as a fetch_req or prog_we SHALL take priority: no write, no response, no count.
REQ-035 Reset mid-RUN SHALL drop any in-flight response (fetch_valid=0 next cycle).

Verification
REQ-036 LOAD: prog_we, addr 4, data 32'h00503223; boot_done; fetch 4 -> next cycle fetch_valid=1, fetch_instr=32'h00503223, fetch_fault=0, fetch_count=1.
REQ-037 Misaligned fetch 6 and fetch DEPTH_BYTES-2 -> fetch_instr=32'h00000013, fetch_fault=1 each, fetch_count increments both times.
REQ-038 prog_we in RUN at addr 4, data 32'hFFFFFFFF -> prog_err=1; subsequent fetch 4 still returns 32'h00503223.
REQ-039 fetch_req held high in LOAD for 5 cycles -> fetch_ready=0, no fetch_valid, fetch_count=0.
REQ-040 Consecutive fetches 0,4,8 on three cycles -> three consecutive fetch_valid pulses with matching words.
REQ-041 Reset asserted one cycle after an accepted fetch -> fetch_valid=0, state LOAD, fetch_count=0, memory word at 4 still readable after the next boot_done.
